counter_monitor: RTL and testbench
==================================

Name: counter_monitor

Overview:
Receive-side checker for a free-running up-counter interface: the counter value bus plus the enable that drives it. Each cycle it samples the bus and the enable and predicts the next value. It locks onto the counter, then flags any step that breaks the rule next = prev + enable (mod 2^WIDTH). It also counts wrap-arounds and errors for on-chip debug, and sits at the board level beside the counter it observes.

Parameters:
WIDTH, 4, width of observed counter value
LOCK_MATCHES, 2, consecutive correct predictions required to enter LOCKED (>=1)
ERR_CNT_WIDTH, 8, width of saturating error counter
WRAP_CNT_WIDTH, 8, width of modulo wrap counter

Ports:
clock_i  in  1  single clock; all logic rising-edge
reset_i  in  1  synchronous, active-high reset
enable_i  in  1  enable as driven to the observed counter
counter_value_i  in  WIDTH  observed counter value
clear_i  in  1  synchronous clear of statistics and lock
locked_o  out  1  high while in LOCKED
expected_o  out  WIDTH  registered prediction for the current sample
error_o  out  1  one-cycle pulse per mismatch detected while LOCKED
error_sticky_o  out  1  set on any error, cleared by reset/clear_i
error_count_o  out  ERR_CNT_WIDTH  saturating error count
wrap_o  out  1  one-cycle pulse per observed max->0 transition while LOCKED
wrap_count_o  out  WRAP_CNT_WIDTH  wrap count, modulo 2^WRAP_CNT_WIDTH

Behaviour:
- Interface: one clock, clock_i; reset_i is synchronous and active-high. No asynchronous logic.
- Every cycle: prev_value <= counter_value_i, prev_en <= enable_i. Prediction: exp = prev_value + prev_en, truncated to WIDTH bits. expected_o = exp.
- match = (counter_value_i == exp), evaluated on the current sample against registered state.
- FSM IDLE / ACQUIRE / LOCKED:
  - IDLE: capture the sample only, then go to ACQUIRE with match_cnt = 0.
  - ACQUIRE: on match, match_cnt++; if match_cnt+1 == LOCKED_MATCHES go to LOCKED. On mismatch, match_cnt = 0 and stay. No errors are flagged in ACQUIRE.
  - LOCKED: on mismatch, go to ACQUIRE (match_cnt = 0), pulse error_o, set error_sticky_o, and increment error_count_o, saturating at all-ones.
- Wrap: in LOCKED, a match with prev_value == all-ones and prev_en == 1 pulses wrap_o and increments wrap_count_o, wrapping modulo 2^WRAP_CNT_WIDTH.
- Output timing: all outputs are registered. error_o, wrap_o and locked_o change in the cycle after the deciding sample.
- Reset and clear: reset_i wins over clear_i. Both force IDLE, match_cnt = 0, and all outputs 0 (expected_o = 0, prev_value = 0, prev_en = 0). A clear_i coincident with a mismatch discards that error.
- Reset mid-operation of the observed counter: its value jumps to 0. This is reported as an error if LOCKED, and the monitor then reacquires.
- Held value (enable = 0) is a legal match. Enable asserted at max value predicts 0.

Test Plan:
1. Pulse reset_i, then enable_i = 1 with counter 0,1,2,3… -> locked_o = 1 in the cycle after the third sample. error_o never asserted; expected_o tracks value + 1 of the previous cycle.
2. While locked, alternate enable_i 1/0 with the counter stepping accordingly (3,3,4,4,5) -> no error_o; locked_o stays 1.
3. While locked, counter jumps 5 -> 7 -> error_o pulses once; error_count_o = 1; error_sticky_o = 1; locked_o = 0. With correct counting afterwards, locked_o returns after 2 matches; error_sticky_o stays 1.
4. Locked, enable_i = 1 for 20 cycles from 10 -> exactly one wrap_o pulse on the 15 -> 0 step; wrap_count_o = 1; no error.
5. With ERR_CNT_WIDTH = 2, inject 5 separated mismatches, each followed by relock -> error_count_o stops at 3; error_o pulses 5 times.
6. Assert clear_i in the same cycle as a mismatch -> error_o = 0; counts = 0; state IDLE. Assert reset_i and clear_i together -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/counter_monitor.sv
// Receive-side checker for a free-running up-counter: locks onto the observed
// value/enable stream and flags any step that breaks next = prev + enable.
module counter_monitor #(
  parameter int WIDTH          = 4,
  parameter int LOCK_MATCHES   = 2,
  parameter int ERR_CNT_WIDTH  = 8,
  parameter int WRAP_CNT_WIDTH = 8
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic [WIDTH-1:0]          counter_value_i,
  input  logic                      clear_i,
  output logic                      locked_o,
  output logic [WIDTH-1:0]          expected_o,
  output logic                      error_o,
  output logic                      error_sticky_o,
  output logic [ERR_CNT_WIDTH-1:0]  error_count_o,
  output logic                      wrap_o,
  output logic [WRAP_CNT_WIDTH-1:0] wrap_count_o
);

  localparam int MC_W = (LOCK_MATCHES < 2) ? 1 : $clog2(LOCK_MATCHES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t                    state_q;
  logic [MC_W-1:0]           match_cnt_q;
  logic [WIDTH-1:0]          prev_value_q;
  logic                      prev_en_q;
  logic [WIDTH-1:0]          expected_q;
  logic                      locked_q;
  logic                      error_q;
  logic                      error_sticky_q;
  logic [ERR_CNT_WIDTH-1:0]  error_count_q;
  logic                      wrap_q;
  logic [WRAP_CNT_WIDTH-1:0] wrap_count_q;

  logic [WIDTH-1:0]          exp_value;
  logic                      match;
  logic                      wrap_step;

  // Prediction from the previous sample, compared against the current one.
  always_comb begin
    exp_value = prev_value_q + {{(WIDTH-1){1'b0}}, prev_en_q};
    match     = (counter_value_i == exp_value);
    wrap_step = (prev_value_q == {WIDTH{1'b1}}) && prev_en_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      state_q        <= IDLE;
      match_cnt_q    <= '0;
      prev_value_q   <= '0;
      prev_en_q      <= 1'b0;
      expected_q     <= '0;
      locked_q       <= 1'b0;
      error_q        <= 1'b0;
      error_sticky_q <= 1'b0;
      error_count_q  <= '0;
      wrap_q         <= 1'b0;
      wrap_count_q   <= '0;
    end else begin
      prev_value_q <= counter_value_i;
      prev_en_q    <= enable_i;
      expected_q   <= counter_value_i + {{(WIDTH-1){1'b0}}, enable_i};
      error_q      <= 1'b0;
      wrap_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q     <= ACQUIRE;
          match_cnt_q <= '0;
          locked_q    <= 1'b0;
        end
        ACQUIRE: begin
          // Lock once the run of consecutive matches reaches LOCK_MATCHES.
          if (match) begin
            if (match_cnt_q == MC_W'(LOCK_MATCHES - 1)) begin
              state_q     <= LOCKED;
              locked_q    <= 1'b1;
              match_cnt_q <= '0;
            end else begin
              match_cnt_q <= match_cnt_q + MC_W'(1);
            end
          end else begin
            match_cnt_q <= '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            state_q        <= ACQUIRE;
            locked_q       <= 1'b0;
            match_cnt_q    <= '0;
            error_q        <= 1'b1;
            error_sticky_q <= 1'b1;
            if (error_count_q != {ERR_CNT_WIDTH{1'b1}}) begin
              error_count_q <= error_count_q + ERR_CNT_WIDTH'(1);
            end
          end else if (wrap_step) begin
            wrap_q       <= 1'b1;
            wrap_count_q <= wrap_count_q + WRAP_CNT_WIDTH'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          locked_q    <= 1'b0;
          match_cnt_q <= '0;
        end
      endcase
    end
  end

  assign locked_o       = locked_q;
  assign expected_o     = expected_q;
  assign error_o        = error_q;
  assign error_sticky_o = error_sticky_q;
  assign error_count_o  = error_count_q;
  assign wrap_o         = wrap_q;
  assign wrap_count_o   = wrap_count_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Self-checking bench for counter_monitor: directed scenarios plus random
// counter streams, compared every cycle against a behavioural model.
module tb_counter_monitor;
  localparam int W  = 4;
  localparam int LM = 2;
  localparam int VMOD = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset = 1'b0, enable = 1'b0, clear = 1'b0;
  logic [W-1:0] value = '0;

  logic         a_locked, a_err, a_sticky, a_wrap;
  logic [W-1:0] a_exp;
  logic [7:0]   a_errcnt, a_wrapcnt;
  logic         b_locked, b_err, b_sticky, b_wrap;
  logic [W-1:0] b_exp;
  logic [1:0]   b_errcnt;
  logic [7:0]   b_wrapcnt;

  counter_monitor #(.WIDTH(W), .LOCK_MATCHES(LM), .ERR_CNT_WIDTH(8), .WRAP_CNT_WIDTH(8)) dut (
    .clock_i(clock), .reset_i(reset), .enable_i(enable), .counter_value_i(value),
    .clear_i(clear), .locked_o(a_locked), .expected_o(a_exp), .error_o(a_err),
    .error_sticky_o(a_sticky), .error_count_o(a_errcnt), .wrap_o(a_wrap),
    .wrap_count_o(a_wrapcnt));

  counter_monitor #(.WIDTH(W), .LOCK_MATCHES(LM), .ERR_CNT_WIDTH(2), .WRAP_CNT_WIDTH(8)) dut_sat (
    .clock_i(clock), .reset_i(reset), .enable_i(enable), .counter_value_i(value),
    .clear_i(clear), .locked_o(b_locked), .expected_o(b_exp), .error_o(b_err),
    .error_sticky_o(b_sticky), .error_count_o(b_errcnt), .wrap_o(b_wrap),
    .wrap_count_o(b_wrapcnt));

  int checks = 0;
  int failures = 0;

  // Behavioural model: what an observer of the counter must conclude.
  bit m_seen, m_locked, m_err, m_wrap, m_sticky;
  int m_run, m_prev, m_pen, m_errs, m_wraps, m_exp;
  int cv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input int v, input int e, input bit clr, input bit rst);
    int  pred;
    bit  hit;
    if (rst || clr) begin
      m_seen = 0; m_locked = 0; m_err = 0; m_wrap = 0; m_sticky = 0;
      m_run = 0; m_prev = 0; m_pen = 0; m_errs = 0; m_wraps = 0; m_exp = 0;
    end else begin
      pred = (m_prev + m_pen) % VMOD;
      hit  = (v == pred);
      m_err = 0; m_wrap = 0;
      if (!m_seen) begin
        m_seen = 1; m_run = 0;
      end else if (!m_locked) begin
        m_run = hit ? m_run + 1 : 0;
        if (m_run == LM) begin m_locked = 1; m_run = 0; end
      end else if (!hit) begin
        m_err = 1; m_sticky = 1; m_errs++; m_locked = 0; m_run = 0;
      end else if (m_prev == VMOD - 1 && m_pen == 1) begin
        m_wrap = 1; m_wraps = (m_wraps + 1) % 256;
      end
      m_prev = v; m_pen = e; m_exp = (v + e) % VMOD;
    end
  endtask

  // One cycle: drive a sample, advance the model, compare after the edge.
  task automatic step(input int v, input int e, input bit clr, input bit rst);
    @(negedge clock);
    value = W'(v); enable = e[0]; clear = clr; reset = rst;
    model_step(v, e, clr, rst);
    @(posedge clock);
    #1;
    chk("locked",     {31'd0, a_locked}, {31'd0, m_locked});
    chk("expected",   {28'd0, a_exp},    m_exp);
    chk("error",      {31'd0, a_err},    {31'd0, m_err});
    chk("sticky",     {31'd0, a_sticky}, {31'd0, m_sticky});
    chk("err_count",  {24'd0, a_errcnt}, min_i(m_errs, 255));
    chk("wrap",       {31'd0, a_wrap},   {31'd0, m_wrap});
    chk("wrap_count", {24'd0, a_wrapcnt}, m_wraps);
    chk("sat_count",  {30'd0, b_errcnt}, min_i(m_errs, 3));
    chk("sat_error",  {31'd0, b_err},    {31'd0, m_err});
  endtask

  task automatic cnt_step(input int e);
    step(cv, e, 1'b0, 1'b0);
    cv = (cv + e) % VMOD;
  endtask

  initial begin
    int nerr, nwrap;
    model_step(0, 0, 1'b0, 1'b1);

    // Reset state.
    step(0, 0, 1'b0, 1'b1);
    chk("lit_reset_locked", {31'd0, a_locked}, 32'd0);
    chk("lit_reset_exp",    {28'd0, a_exp},    32'd0);

    // Acquire: locked after the third sample 0,1,2.
    cv = 0;
    cnt_step(1); cnt_step(1);
    chk("lit_not_yet_locked", {31'd0, a_locked}, 32'd0);
    cnt_step(1);
    chk("lit_locked", {31'd0, a_locked}, 32'd1);
    chk("lit_exp3",   {28'd0, a_exp},    32'd3);

    // Held values are legal: 3,3,4,4,5.
    cnt_step(0); cnt_step(1); cnt_step(0); cnt_step(1); cnt_step(1);
    chk("lit_hold_locked", {31'd0, a_locked}, 32'd1);
    chk("lit_hold_noerr",  {31'd0, a_sticky}, 32'd0);

    // Jump 5 -> 7.
    cv = 7;
    cnt_step(1);
    chk("lit_jump_err",    {31'd0, a_err},    32'd1);
    chk("lit_jump_cnt",    {24'd0, a_errcnt}, 32'd1);
    chk("lit_jump_unlock", {31'd0, a_locked}, 32'd0);
    cnt_step(1); cnt_step(1);
    chk("lit_relock",        {31'd0, a_locked}, 32'd1);
    chk("lit_sticky_stays",  {31'd0, a_sticky}, 32'd1);

    // Wrap 15 -> 0 over 20 enabled steps starting at 10.
    nwrap = 0; nerr = 0;
    for (int i = 0; i < 20; i++) begin
      cnt_step(1);
      nwrap += a_wrap; nerr += a_err;
    end
    chk("lit_wrap_pulses", nwrap, 32'd1);
    chk("lit_wrap_count",  {24'd0, a_wrapcnt}, 32'd1);
    chk("lit_wrap_noerr",  nerr, 32'd0);

    // Clear coincident with a mismatch discards the error.
    step((cv + 3) % VMOD, 1, 1'b1, 1'b0);
    chk("lit_clr_err",    {31'd0, a_err},    32'd0);
    chk("lit_clr_cnt",    {24'd0, a_errcnt}, 32'd0);
    chk("lit_clr_locked", {31'd0, a_locked}, 32'd0);

    // Five separated mismatches: wide count 5, narrow count saturates at 3.
    cv = 0; nerr = 0;
    for (int k = 0; k < 5; k++) begin
      cnt_step(1); cnt_step(1); cnt_step(1);
      cv = (cv + 5) % VMOD;
      cnt_step(1);
      nerr += b_err;
    end
    chk("lit_sat_pulses", nerr, 32'd5);
    chk("lit_sat_cnt",    {30'd0, b_errcnt}, 32'd3);
    chk("lit_wide_cnt",   {24'd0, a_errcnt}, 32'd5);

    // Reset and clear together.
    step(9, 1, 1'b1, 1'b1);
    chk("lit_rc_sticky", {31'd0, a_sticky}, 32'd0);
    chk("lit_rc_wrapc",  {24'd0, a_wrapcnt}, 32'd0);

    // Random streams: mostly correct counting with jumps, clears, resets.
    cv = $urandom_range(0, VMOD - 1);
    for (int i = 0; i < 3000; i++) begin
      int e;
      bit clr, rst;
      e   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      clr = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) cv = $urandom_range(0, VMOD - 1);
      step(cv, e, clr, rst);
      cv = (cv + e) % VMOD;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
